// File: rtl/logic_unit_arbiter_if.sv
// Request/result bus for the shared logic unit.
//   Requester A: a_valid, a_ready, a_op, a_x, a_y
//   Requester B: b_valid, b_ready, b_op, b_x, b_y
//   Result     : res_valid, res_ready, res_data, res_id (0 = A, 1 = B)
// The slave modport is the arbiter side; master is the requester/consumer side.
interface logic_unit_arbiter_if #(
   parameter int WIDTH = 4
);
   logic             a_valid;
   logic             a_ready;
   logic [1:0]       a_op;
   logic [WIDTH-1:0] a_x;
   logic [WIDTH-1:0] a_y;
   logic             b_valid;
   logic             b_ready;
   logic [1:0]       b_op;
   logic [WIDTH-1:0] b_x;
   logic [WIDTH-1:0] b_y;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_id;

   modport slave (
      input  a_valid, a_op, a_x, a_y,
      input  b_valid, b_op, b_x, b_y,
      input  res_ready,
      output a_ready, b_ready,
      output res_valid, res_data, res_id
   );

   modport master (
      output a_valid, a_op, a_x, a_y,
      output b_valid, b_op, b_x, b_y,
      output res_ready,
      input  a_ready, b_ready,
      input  res_valid, res_data, res_id
   );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOT) between two
// requesters with round-robin arbitration and a three-state
// capture/execute/hold sequence.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        request/result bus (slave side)
//   a_done_cnt saturating count of results accepted for A
//   b_done_cnt saturating count of results accepted for B
module logic_unit_arbiter #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   logic_unit_arbiter_if.slave  bus,
   output logic [CNT_W-1:0]     a_done_cnt,
   output logic [CNT_W-1:0]     b_done_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state;
   logic             last_gnt;   // owner of the last accepted result: 0 = A, 1 = B
   logic [1:0]       op_p0;
   logic [WIDTH-1:0] x_p0;
   logic [WIDTH-1:0] y_p0;
   logic             id_p0;
   logic             gnt_a;
   logic             gnt_b;

   function automatic logic [WIDTH-1:0] logic_op(input logic [1:0]       op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] r;
      case (op)
         2'b00:   r = x & y;
         2'b01:   r = x | y;
         2'b10:   r = x ^ y;
         default: r = ~x;
      endcase
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Grant only in IDLE. When both request, the side that did not own the
   // last accepted result wins; last_gnt resets to B so A wins first.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (state == IDLE) begin
         if (bus.a_valid && (!bus.b_valid || last_gnt))
            gnt_a = 1'b1;
         else if (bus.b_valid)
            gnt_b = 1'b1;
      end
   end

   assign bus.a_ready = gnt_a;
   assign bus.b_ready = gnt_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         last_gnt      <= 1'b1;
         op_p0         <= 2'b00;
         x_p0          <= '0;
         y_p0          <= '0;
         id_p0         <= 1'b0;
         bus.res_valid <= 1'b0;
         bus.res_data  <= '0;
         bus.res_id    <= 1'b0;
         a_done_cnt    <= '0;
         b_done_cnt    <= '0;
      end else begin
         case (state)
            // capture stage: latch the granted request
            IDLE: begin
               if (gnt_a || gnt_b) begin
                  op_p0 <= gnt_b ? bus.b_op : bus.a_op;
                  x_p0  <= gnt_b ? bus.b_x  : bus.a_x;
                  y_p0  <= gnt_b ? bus.b_y  : bus.a_y;
                  id_p0 <= gnt_b;
                  state <= EXEC;
               end
            end
            // execute stage: compute and present the result
            EXEC: begin
               bus.res_data  <= logic_op(op_p0, x_p0, y_p0);
               bus.res_id    <= id_p0;
               bus.res_valid <= 1'b1;
               state         <= HOLD;
            end
            // hold stage: keep the result until the consumer takes it
            HOLD: begin
               if (bus.res_ready) begin
                  bus.res_valid <= 1'b0;
                  if (bus.res_id)
                     b_done_cnt <= sat_inc(b_done_cnt);
                  else
                     a_done_cnt <= sat_inc(a_done_cnt);
                  last_gnt <= bus.res_id;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] a_done_cnt;
   logic [7:0] b_done_cnt;

   logic_unit_arbiter_if #(.WIDTH(4)) bus ();

   logic_unit_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .a_done_cnt (a_done_cnt),
      .b_done_cnt (b_done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       av;
      logic [1:0] aop;
      logic [3:0] ax;
      logic [3:0] ay;
      logic       bv;
      logic [1:0] bop;
      logic [3:0] bx;
      logic [3:0] by;
      int         stall;
      int         win;       // -1 none, 0 A, 1 B
      logic [3:0] exp_data;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int last_owner = 1;
   int a_cnt = 0;
   int b_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] ref_op(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y);
      logic [3:0] r;
      r = 4'h0;
      for (int i = 0; i < 4; i++) begin
         int s;
         s = int'(x[i]) + int'(y[i]);
         case (op)
            2'd0: r[i] = (s == 2);
            2'd1: r[i] = (s >= 1);
            2'd2: r[i] = (s == 1);
            default: r[i] = (x[i] == 1'b0);
         endcase
      end
      return r;
   endfunction

   function automatic vec_t model_vec(input logic av, input logic [1:0] aop, input logic [3:0] ax,
                                      input logic [3:0] ay, input logic bv, input logic [1:0] bop,
                                      input logic [3:0] bx, input logic [3:0] by, input int stall);
      vec_t v;
      v = '{av, aop, ax, ay, bv, bop, bx, by, stall, -1, 4'h0};
      if (av && bv)  v.win = (last_owner == 0) ? 1 : 0;
      else if (av)   v.win = 0;
      else if (bv)   v.win = 1;
      if (v.win == 0)      v.exp_data = ref_op(aop, ax, ay);
      else if (v.win == 1) v.exp_data = ref_op(bop, bx, by);
      return v;
   endfunction

   task automatic transact(input vec_t v);
      @(negedge clk);
      bus.a_valid = v.av; bus.a_op = v.aop; bus.a_x = v.ax; bus.a_y = v.ay;
      bus.b_valid = v.bv; bus.b_op = v.bop; bus.b_x = v.bx; bus.b_y = v.by;
      bus.res_ready = 1'b0;
      #1;
      check("a_ready_grant", 32'(bus.a_ready), 32'(v.win == 0));
      check("b_ready_grant", 32'(bus.b_ready), 32'(v.win == 1));
      if (v.win < 0) begin
         check("idle_res_valid", 32'(bus.res_valid), 32'(0));
         bus.a_valid = 1'b0;
         bus.b_valid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      // scramble operands after the grant; they must not matter any more
      bus.a_x = 4'(~v.ax); bus.b_x = 4'(~v.bx);
      #1;
      check("exec_ready", 32'({bus.a_ready, bus.b_ready}), 32'(0));
      check("exec_res_valid", 32'(bus.res_valid), 32'(0));
      @(negedge clk);
      #1;
      check("res_valid", 32'(bus.res_valid), 32'(1));
      check("res_data", 32'(bus.res_data), 32'(v.exp_data));
      check("res_id", 32'(bus.res_id), 32'(v.win));
      for (int i = 0; i < v.stall; i++) begin
         bus.a_valid = 1'b1;
         bus.b_valid = 1'b1;
         @(negedge clk);
         #1;
         check("hold_valid", 32'(bus.res_valid), 32'(1));
         check("hold_data", 32'(bus.res_data), 32'(v.exp_data));
         check("hold_id", 32'(bus.res_id), 32'(v.win));
         check("hold_ready", 32'({bus.a_ready, bus.b_ready}), 32'(0));
      end
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      #1;
      check("accept_res_valid", 32'(bus.res_valid), 32'(0));
      if (v.win == 0) begin
         if (a_cnt < 255) a_cnt++;
      end else begin
         if (b_cnt < 255) b_cnt++;
      end
      last_owner = v.win;
      check("a_done_cnt", 32'(a_done_cnt), 32'(a_cnt));
      check("b_done_cnt", 32'(b_done_cnt), 32'(b_cnt));
   endtask

   function automatic vec_t rand_vec(input logic av, input logic bv, input int stall);
      return model_vec(av, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       bv, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       stall);
   endfunction

   vec_t tbl [7];

   initial begin
      // directed vectors, in order from reset (A wins the first tie)
      tbl[0] = '{1'b1, 2'd2, 4'hF, 4'h3, 1'b1, 2'd1, 4'h1, 4'h2, 0, 0, 4'hC};
      tbl[1] = '{1'b1, 2'd2, 4'hF, 4'h3, 1'b1, 2'd1, 4'h1, 4'h2, 0, 1, 4'h3};
      tbl[2] = '{1'b1, 2'd0, 4'hC, 4'hA, 1'b0, 2'd0, 4'h0, 4'h0, 0, 0, 4'h8};
      tbl[3] = '{1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 2'd3, 4'h5, 4'hF, 5, 1, 4'hA};
      tbl[4] = '{1'b1, 2'd1, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0, 0, 0, 4'h0};
      tbl[5] = '{1'b1, 2'd3, 4'h0, 4'h7, 1'b1, 2'd0, 4'hF, 4'hF, 1, 1, 4'hF};
      tbl[6] = '{1'b1, 2'd2, 4'h6, 4'h5, 1'b1, 2'd1, 4'h8, 4'h1, 0, 0, 4'h3};

      rst_n = 1'b0;
      bus.a_valid = 1'b0; bus.a_op = 2'd0; bus.a_x = 4'h0; bus.a_y = 4'h0;
      bus.b_valid = 1'b0; bus.b_op = 2'd0; bus.b_x = 4'h0; bus.b_y = 4'h0;
      bus.res_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_res_valid", 32'(bus.res_valid), 32'(0));
      check("rst_res_data", 32'(bus.res_data), 32'(0));
      check("rst_res_id", 32'(bus.res_id), 32'(0));
      check("rst_a_cnt", 32'(a_done_cnt), 32'(0));
      check("rst_b_cnt", 32'(b_done_cnt), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) transact(tbl[i]);
      transact(model_vec(1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0, 0));

      // reset while executing: op is dropped, counters and pointer cleared
      @(negedge clk);
      bus.a_valid = 1'b1; bus.a_op = 2'd2; bus.a_x = 4'hF; bus.a_y = 4'h0;
      #1;
      check("pre_rst_a_ready", 32'(bus.a_ready), 32'(1));
      @(negedge clk);
      bus.a_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_res_valid", 32'(bus.res_valid), 32'(0));
      check("midrst_a_cnt", 32'(a_done_cnt), 32'(0));
      check("midrst_b_cnt", 32'(b_done_cnt), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("post_rst_res_valid", 32'(bus.res_valid), 32'(0));
      a_cnt = 0; b_cnt = 0; last_owner = 1;
      transact('{1'b1, 2'd1, 4'h4, 4'h1, 1'b1, 2'd0, 4'hF, 4'hF, 0, 0, 4'h5});

      // saturation of A's counter
      for (int i = 0; i < 260; i++) transact(rand_vec(1'b1, 1'b0, 0));
      check("a_cnt_saturated", 32'(a_done_cnt), 32'(8'hFF));

      // continuous contention must alternate
      for (int i = 0; i < 20; i++) transact(rand_vec(1'b1, 1'b1, 0));

      // random mix with random consumer stalls
      for (int i = 0; i < 150; i++)
         transact(rand_vec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
